csr_unit: RTL and testbench
===========================

// Module: csr_unit
// PURPOSE
//   Machine-mode control/status register file for the multicycle RISC-V core.
//   Handles CSR read, write, set and clear accesses from the controller.
//   Tracks interrupt state: enable, pending, saved PC and cause.
//   Outputs the trap vector, return PC and an interrupt-pending request to the controller.
// PARAMETERS
//   RESET_MTVEC  32'h0000_0000  mtvec value after reset
// PORTS
//   clk_i        in   1   clock; all state updates on rising edge
//   rst_i        in   1   reset, synchronous, active-high
//   addr_i       in   12  CSR address for read and for write/set/clear
//   wdata_i      in   32  write data, or set/clear mask
//   irq_i        in   1   external interrupt request line (level)
//   pc_i         in   32  PC of the interrupted instruction
//   write_i      in   1   CSR write: csr <= wdata_i
//   set_i        in   1   CSR set: csr <= csr | wdata_i
//   clear_i      in   1   CSR clear: csr <= csr & ~wdata_i
//   interrupt_i  in   1   take interrupt this cycle
//   mret_i       in   1   return from trap this cycle
//   rdata_o      out  32  combinational read of the CSR at addr_i; 0 if unmapped
//   mtvec_o      out  32  current mtvec
//   mepc_o       out  32  current mepc
//   ipending_o   out  1   mstatus.MIE & mie.MBIE & mip.MBIP (combinational)
// BEHAVIOUR
//   Map: mstatus 0x300, mie 0x304, mtvec 0x305, mepc 0x341, mcause 0x342, mip 0x344.
//   Bit positions: MIE=3, MPIE=7, MPP=12:11 (reads 2'b11, read-only), MBIE=11, MBIP=11.
//   Reset values: mstatus=32'h1800, mie=0, mtvec=RESET_MTVEC, mepc=0, mcause=0, mip=0.
//   Reset outputs: mtvec_o=RESET_MTVEC, mepc_o=0, ipending_o=0.
//   Writable bits:
//     - mstatus: bits 3 and 7 only.
//     - mie: bit 11 only.
//     - mtvec, mepc: [31:2]; [1:0] read 0.
//     - mcause: all 32 bits.
//     - mip: read-only to software.
//   Access priority when several are asserted: write_i > set_i > clear_i; one op per cycle.
//   Writes to unmapped or read-only addresses are ignored.
//   mip.MBIP <= irq_i every cycle (registered, one-cycle latency). All other mip bits are 0.
//   interrupt_i: mepc <= pc_i; mcause <= 32'h8000_0800; MPIE <= MIE; MIE <= 0.
//   mret_i: MIE <= MPIE; MPIE <= 1.
//   interrupt_i overrides mret_i and any software access to the same register in that cycle.
//   mret_i overrides a software access to mstatus in the same cycle.
//   All register updates are visible on rdata_o/mtvec_o/mepc_o one cycle after the edge.
// CONFIGURATION
//   CSR_MSCRATCH_EN defined: adds mscratch at 0x340, 32-bit read/write/set/clear, reset 0.
//   Without CSR_MSCRATCH_EN: 0x340 is unmapped; it reads 0 and writes are ignored.
// STRUCTURE
//   csr_pkg holds: CSR address localparams; bit-index localparams (MIE, MPIE, MBIE, MBIP);
//   the mcause interrupt constant 32'h8000_0800; the mstatus reset constant 32'h1800.
//   Sub-module csr_wdata_mux: combinational new = f(old, wdata_i, write/set/clear),
//   instanced once and shared by all registers.
// TESTING
//   Reset, read 0x300 -> rdata_o=32'h1800; mtvec_o=RESET_MTVEC; ipending_o=0.
//   write_i, addr 0x305, wdata 32'h1000_0000 -> next cycle mtvec_o=32'h1000_0000.
//   Set MIE via set_i 0x300 (wdata 0x8); pc_i=32'h2000_0000, pulse interrupt_i ->
//     mepc_o=32'h2000_0000; read 0x342 = 32'h8000_0800; mstatus=32'h1880.
//   irq_i=1 while mie=0 -> ipending_o stays 0;
//     then set_i 0x304 wdata 0x800 with MIE=1 -> ipending_o=1 while irq_i held.
//   mret_i pulse after the trap -> mstatus bits 7 and 3 = 1 (32'h1888);
//     clear_i 0x304 wdata 0x800 -> mie reads 0.
//   write_i+set_i+clear_i on 0x304 with wdata 32'hFFFF_FFFF -> mie=32'h800 (write wins);
//     with and without CSR_MSCRATCH_EN, write 0x340 then read back: value / 0.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared CSR addresses, bit positions and constants for csr_unit.
// Optional mscratch register is enabled with the CSR_MSCRATCH_EN macro.
package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MIP      = 12'h344;

    localparam int MIE_BIT  = 3;
    localparam int MPIE_BIT = 7;
    localparam int MBIE_BIT = 11;
    localparam int MBIP_BIT = 11;

    localparam logic [31:0] MCAUSE_IRQ  = 32'h8000_0800;
    localparam logic [31:0] MSTATUS_RST = 32'h0000_1800;
    localparam logic [31:0] ALIGN_MASK  = 32'hFFFF_FFFC;

endpackage

// File: rtl/csr_wdata_mux.sv
// Computes the post-access value of a CSR from its old value and the mask.
// Write beats set, set beats clear.
module csr_wdata_mux (
    input  logic [31:0] old_i,
    input  logic [31:0] wdata_i,
    input  logic        write_i,
    input  logic        set_i,
    input  logic        clear_i,
    output logic [31:0] new_o
);

    always_comb begin
        new_o = old_i;
        if (write_i) begin
            new_o = wdata_i;
        end else if (set_i) begin
            new_o = old_i | wdata_i;
        end else if (clear_i) begin
            new_o = old_i & ~wdata_i;
        end
    end

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR file: software access, interrupt entry and mret.
// Define CSR_MSCRATCH_EN to add the mscratch register at 0x340.
module csr_unit
    import csr_pkg::*;
#(
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [11:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic        irq_i,
    input  logic [31:0] pc_i,
    input  logic        write_i,
    input  logic        set_i,
    input  logic        clear_i,
    input  logic        interrupt_i,
    input  logic        mret_i,
    output logic [31:0] rdata_o,
    output logic [31:0] mtvec_o,
    output logic [31:0] mepc_o,
    output logic        ipending_o
);

    logic        mie_q, mie_d;
    logic        mpie_q, mpie_d;
    logic        mbie_q, mbie_d;
    logic        mbip_q, mbip_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
`ifdef CSR_MSCRATCH_EN
    logic [31:0] mscratch_q, mscratch_d;
`endif

    logic [31:0] mstatus_rd;
    logic [31:0] wnew;
    logic        sw_op;

    assign sw_op = write_i | set_i | clear_i;

    always_comb begin
        mstatus_rd = MSTATUS_RST;
        mstatus_rd[MIE_BIT] = mie_q;
        mstatus_rd[MPIE_BIT] = mpie_q;
    end

    always_comb begin
        rdata_o = 32'h0;
        case (addr_i)
            CSR_MSTATUS:  rdata_o = mstatus_rd;
            CSR_MIE:      rdata_o[MBIE_BIT] = mbie_q;
            CSR_MTVEC:    rdata_o = mtvec_q & ALIGN_MASK;
            CSR_MEPC:     rdata_o = mepc_q & ALIGN_MASK;
            CSR_MCAUSE:   rdata_o = mcause_q;
            CSR_MIP:      rdata_o[MBIP_BIT] = mbip_q;
`ifdef CSR_MSCRATCH_EN
            CSR_MSCRATCH: rdata_o = mscratch_q;
`endif
            default:      rdata_o = 32'h0;
        endcase
    end

    csr_wdata_mux u_wdata_mux (
        .old_i   (rdata_o),
        .wdata_i (wdata_i),
        .write_i (write_i),
        .set_i   (set_i),
        .clear_i (clear_i),
        .new_o   (wnew)
    );

    // Later assignments win: software < mret < interrupt.
    always_comb begin
        mie_d    = mie_q;
        mpie_d   = mpie_q;
        mbie_d   = mbie_q;
        mbip_d   = irq_i;
        mtvec_d  = mtvec_q;
        mepc_d   = mepc_q;
        mcause_d = mcause_q;
`ifdef CSR_MSCRATCH_EN
        mscratch_d = mscratch_q;
`endif
        if (sw_op) begin
            case (addr_i)
                CSR_MSTATUS: begin
                    mie_d  = wnew[MIE_BIT];
                    mpie_d = wnew[MPIE_BIT];
                end
                CSR_MIE:      mbie_d = wnew[MBIE_BIT];
                CSR_MTVEC:    mtvec_d = wnew & ALIGN_MASK;
                CSR_MEPC:     mepc_d = wnew & ALIGN_MASK;
                CSR_MCAUSE:   mcause_d = wnew;
`ifdef CSR_MSCRATCH_EN
                CSR_MSCRATCH: mscratch_d = wnew;
`endif
                default: ;
            endcase
        end
        if (mret_i) begin
            mie_d  = mpie_q;
            mpie_d = 1'b1;
        end
        if (interrupt_i) begin
            mepc_d   = pc_i & ALIGN_MASK;
            mcause_d = MCAUSE_IRQ;
            mpie_d   = mie_q;
            mie_d    = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mie_q    <= MSTATUS_RST[MIE_BIT];
            mpie_q   <= MSTATUS_RST[MPIE_BIT];
            mbie_q   <= 1'b0;
            mbip_q   <= 1'b0;
            mtvec_q  <= RESET_MTVEC;
            mepc_q   <= 32'h0;
            mcause_q <= 32'h0;
        end else begin
            mie_q    <= mie_d;
            mpie_q   <= mpie_d;
            mbie_q   <= mbie_d;
            mbip_q   <= mbip_d;
            mtvec_q  <= mtvec_d;
            mepc_q   <= mepc_d;
            mcause_q <= mcause_d;
        end
    end

`ifdef CSR_MSCRATCH_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mscratch_q <= 32'h0;
        end else begin
            mscratch_q <= mscratch_d;
        end
    end
`endif

    assign mtvec_o    = mtvec_q & ALIGN_MASK;
    assign mepc_o     = mepc_q & ALIGN_MASK;
    assign ipending_o = mie_q & mbie_q & mbip_q;

endmodule

// File: tb/tb_csr_unit.sv
// Directed self-checking bench for csr_unit.
// Honours CSR_MSCRATCH_EN for the mscratch read-back expectation.
module tb_csr_unit;

    localparam logic [31:0] RST_VEC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] addr = 12'h0;
    logic [31:0] wdata = 32'h0;
    logic        irq = 1'b0;
    logic [31:0] pc = 32'h0;
    logic        wr = 1'b0;
    logic        st = 1'b0;
    logic        cl = 1'b0;
    logic        intr = 1'b0;
    logic        mret = 1'b0;
    logic [31:0] rdata;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic        ipend;

    int n_assert = 0;
    int n_fail = 0;

    csr_unit #(.RESET_MTVEC(RST_VEC)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .addr_i      (addr),
        .wdata_i     (wdata),
        .irq_i       (irq),
        .pc_i        (pc),
        .write_i     (wr),
        .set_i       (st),
        .clear_i     (cl),
        .interrupt_i (intr),
        .mret_i      (mret),
        .rdata_o     (rdata),
        .mtvec_o     (mtvec),
        .mepc_o      (mepc),
        .ipending_o  (ipend)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        wr = 1'b0; st = 1'b0; cl = 1'b0;
        intr = 1'b0; mret = 1'b0;
    endtask

    task automatic op(input logic [11:0] a, input logic [31:0] d,
                      input logic w, input logic s, input logic c);
        addr = a; wdata = d; wr = w; st = s; cl = c;
        tick();
    endtask

    task automatic rd(input string tag, input logic [11:0] a,
                      input logic [31:0] exp);
        addr = a;
        #1;
        chk(tag, rdata, exp);
    endtask

    initial begin
        logic [31:0] scratch_exp;
        tick();
        tick();
        rst = 1'b0;
        #1;
        rd("rst_mstatus", 12'h300, 32'h0000_1800);
        chk("rst_mtvec", mtvec, RST_VEC);
        chk("rst_mepc", mepc, 32'h0);
        chk("rst_ipend", {31'h0, ipend}, 32'h0);
        rd("rst_mie", 12'h304, 32'h0);
        rd("rst_mcause", 12'h342, 32'h0);
        rd("rst_mip", 12'h344, 32'h0);

        op(12'h305, 32'h1000_0003, 1'b1, 1'b0, 1'b0);
        chk("mtvec_wr", mtvec, 32'h1000_0000);
        rd("mtvec_rd", 12'h305, 32'h1000_0000);

        op(12'h300, 32'h0000_0008, 1'b0, 1'b1, 1'b0);
        rd("set_mie", 12'h300, 32'h0000_1808);

        pc = 32'h2000_0000;
        intr = 1'b1;
        tick();
        chk("trap_mepc", mepc, 32'h2000_0000);
        rd("trap_mcause", 12'h342, 32'h8000_0800);
        rd("trap_mstatus", 12'h300, 32'h0000_1880);

        irq = 1'b1;
        rd("mip_lat", 12'h344, 32'h0);
        tick();
        rd("mip_set", 12'h344, 32'h0000_0800);
        chk("ipend_mie0", {31'h0, ipend}, 32'h0);

        mret = 1'b1;
        tick();
        rd("mret_mstatus", 12'h300, 32'h0000_1888);
        chk("ipend_mbie0", {31'h0, ipend}, 32'h0);

        op(12'h304, 32'h0000_0800, 1'b0, 1'b1, 1'b0);
        rd("mie_set", 12'h304, 32'h0000_0800);
        chk("ipend_on", {31'h0, ipend}, 32'h1);

        op(12'h304, 32'h0000_0800, 1'b0, 1'b0, 1'b1);
        rd("mie_clr", 12'h304, 32'h0);
        chk("ipend_off", {31'h0, ipend}, 32'h0);

        op(12'h304, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b1);
        rd("mie_all", 12'h304, 32'h0000_0800);

        op(12'h342, 32'h0000_00F0, 1'b1, 1'b1, 1'b1);
        rd("prio_wr", 12'h342, 32'h0000_00F0);
        op(12'h342, 32'h0000_000F, 1'b0, 1'b1, 1'b1);
        rd("prio_set", 12'h342, 32'h0000_00FF);
        op(12'h342, 32'h0000_00F0, 1'b0, 1'b0, 1'b1);
        rd("mcause_clr", 12'h342, 32'h0000_000F);

`ifdef CSR_MSCRATCH_EN
        scratch_exp = 32'hDEAD_BEEF;
`else
        scratch_exp = 32'h0;
`endif
        op(12'h340, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0);
        rd("mscratch", 12'h340, scratch_exp);

        addr = 12'h341; wdata = 32'h0000_1234; wr = 1'b1;
        pc = 32'h3000_0006; intr = 1'b1; mret = 1'b1;
        tick();
        chk("int_ovr_mepc", mepc, 32'h3000_0004);
        rd("int_ovr_mret", 12'h300, 32'h0000_1880);

        addr = 12'h300; wdata = 32'h0; wr = 1'b1; mret = 1'b1;
        tick();
        rd("mret_ovr_sw", 12'h300, 32'h0000_1888);

        op(12'h300, 32'h0, 1'b1, 1'b0, 1'b0);
        rd("mstatus_wr0", 12'h300, 32'h0000_1800);
        op(12'h300, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        rd("mstatus_wr1", 12'h300, 32'h0000_1888);

        op(12'h341, 32'h0000_5557, 1'b1, 1'b0, 1'b0);
        chk("mepc_align", mepc, 32'h0000_5554);

        irq = 1'b0;
        op(12'h344, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        rd("mip_ro", 12'h344, 32'h0);
        op(12'h7C0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        rd("unmapped", 12'h7C0, 32'h0);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst2_mtvec", mtvec, RST_VEC);
        rd("rst2_mstatus", 12'h300, 32'h0000_1800);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
